// File: rtl/id_branch_ctrl_if.sv
// Branch-controller bus: hazard/forwarding inputs from the pipeline stages,
// comparator result, and the stall/redirect/forward-select outputs.
interface id_branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic [1:0]       br_op;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             ex_we;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic             mem_we;
  logic             mem_is_load;
  logic [4:0]       mem_rd;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [1:0]       cmp;
  logic             ex_redirect;
  logic             stall;
  logic             bubble_ex;
  logic             pc_sel;
  logic             flush_if;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: drives stage info, consumes control decisions.
  modport master (
    output br_valid, br_op, rs1, rs2, ex_we, ex_is_load, ex_rd,
           mem_we, mem_is_load, mem_rd, wb_we, wb_rd, cmp, ex_redirect,
    input  stall, bubble_ex, pc_sel, flush_if, fwd_a, fwd_b, taken_cnt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  br_valid, br_op, rs1, rs2, ex_we, ex_is_load, ex_rd,
           mem_we, mem_is_load, mem_rd, wb_we, wb_rd, cmp, ex_redirect,
    output stall, bubble_ex, pc_sel, flush_if, fwd_a, fwd_b, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/id_branch_ctrl.sv
// ID-stage branch resolution controller: stalls on operand hazards, selects
// operand forwarding, resolves the branch from the comparator result and
// issues PC redirect + IF/ID flush. Keeps saturating taken/stall counters.
module id_branch_ctrl #(
  parameter int LOAD_STALL = 2,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  id_branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0]       LOAD_N     = 2'(LOAD_STALL);
  localparam logic [1:0]       MEM_LOAD_N = 2'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  // Stall cycles one operand needs; a younger EX producer shadows MEM.
  function automatic logic [1:0] operandNeed(
    input logic [4:0] rs,
    input logic       exWe,
    input logic       exLoad,
    input logic [4:0] exRd,
    input logic       memWe,
    input logic       memLoad,
    input logic [4:0] memRd
  );
    logic [1:0] n;
    if (rs == 5'd0) begin
      n = 2'd0;
    end else if (exWe && (exRd == rs)) begin
      n = exLoad ? LOAD_N : 2'd1;
    end else if (memWe && memLoad && (memRd == rs)) begin
      n = MEM_LOAD_N;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

  // Forward select for one operand: MEM ALU result beats WB data.
  function automatic logic [1:0] operandFwd(
    input logic [4:0] rs,
    input logic       memWe,
    input logic       memLoad,
    input logic [4:0] memRd,
    input logic       wbWe,
    input logic [4:0] wbRd
  );
    logic [1:0] sel;
    if (rs == 5'd0) begin
      sel = 2'b00;
    end else if (memWe && !memLoad && (memRd == rs)) begin
      sel = 2'b01;
    end else if (wbWe && (wbRd == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Branch condition from opcode and comparator code; cmp=11 never takes.
  function automatic logic branchTaken(input logic [1:0] op, input logic [1:0] c);
    logic t;
    case (op)
      2'b00:   t = (c == 2'b00);
      2'b01:   t = (c == 2'b01) || (c == 2'b10);
      2'b10:   t = (c == 2'b01);
      2'b11:   t = (c == 2'b00) || (c == 2'b10);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t           stateR;
  state_t           stateNextS;
  logic [1:0]       cntR;
  logic [1:0]       cntNextS;
  logic [1:0]       needAS;
  logic [1:0]       needBS;
  logic [1:0]       needS;
  logic             stallS;
  logic             resolveS;
  logic             takenS;
  logic [CNT_W-1:0] takenCntR;
  logic [CNT_W-1:0] stallCntR;

  assign needAS = operandNeed(bus.rs1, bus.ex_we, bus.ex_is_load, bus.ex_rd,
                              bus.mem_we, bus.mem_is_load, bus.mem_rd);
  assign needBS = operandNeed(bus.rs2, bus.ex_we, bus.ex_is_load, bus.ex_rd,
                              bus.mem_we, bus.mem_is_load, bus.mem_rd);
  assign needS  = (needAS > needBS) ? needAS : needBS;

  // State register with the remaining-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= IDLE;
      cntR   <= 2'd0;
    end else begin
      stateR <= stateNextS;
      cntR   <= cntNextS;
    end
  end

  // Next-state logic; an older redirect kills the branch from any state.
  always_comb begin
    stateNextS = IDLE;
    cntNextS   = 2'd0;
    if (bus.ex_redirect) begin
      stateNextS = IDLE;
      cntNextS   = 2'd0;
    end else begin
      case (stateR)
        IDLE: begin
          if (bus.br_valid && (needS == 2'd1)) begin
            stateNextS = RESOLVE;
            cntNextS   = 2'd0;
          end else if (bus.br_valid && (needS > 2'd1)) begin
            stateNextS = WAIT;
            cntNextS   = needS - 2'd1;
          end else begin
            stateNextS = IDLE;
            cntNextS   = 2'd0;
          end
        end
        WAIT: begin
          if (cntR <= 2'd1) begin
            stateNextS = RESOLVE;
            cntNextS   = 2'd0;
          end else begin
            stateNextS = WAIT;
            cntNextS   = cntR - 2'd1;
          end
        end
        RESOLVE: begin
          stateNextS = IDLE;
          cntNextS   = 2'd0;
        end
        default: begin
          stateNextS = IDLE;
          cntNextS   = 2'd0;
        end
      endcase
    end
  end

  // Output decode: stall/resolve per state, forwarding in every state, all zero in reset.
  always_comb begin
    stallS   = 1'b0;
    resolveS = 1'b0;
    if (bus.ex_redirect) begin
      stallS   = 1'b0;
      resolveS = 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (bus.br_valid && (needS == 2'd0)) begin
            resolveS = 1'b1;
          end else if (bus.br_valid) begin
            stallS = 1'b1;
          end else begin
            stallS = 1'b0;
          end
        end
        WAIT:    stallS   = 1'b1;
        RESOLVE: resolveS = 1'b1;
        default: stallS   = 1'b0;
      endcase
    end
    takenS = resolveS && branchTaken(bus.br_op, bus.cmp);
    if (!rst_n) begin
      bus.stall     = 1'b0;
      bus.bubble_ex = 1'b0;
      bus.pc_sel    = 1'b0;
      bus.flush_if  = 1'b0;
      bus.fwd_a     = 2'b00;
      bus.fwd_b     = 2'b00;
    end else begin
      bus.stall     = stallS;
      bus.bubble_ex = stallS;
      bus.pc_sel    = takenS;
      bus.flush_if  = takenS;
      bus.fwd_a     = operandFwd(bus.rs1, bus.mem_we, bus.mem_is_load, bus.mem_rd,
                                 bus.wb_we, bus.wb_rd);
      bus.fwd_b     = operandFwd(bus.rs2, bus.mem_we, bus.mem_is_load, bus.mem_rd,
                                 bus.wb_we, bus.wb_rd);
    end
  end

  // Saturating performance counters for taken branches and stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takenCntR <= {CNT_W{1'b0}};
      stallCntR <= {CNT_W{1'b0}};
    end else begin
      if (takenS && (takenCntR != CNT_MAX)) begin
        takenCntR <= takenCntR + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        takenCntR <= takenCntR;
      end
      if (stallS && (stallCntR != CNT_MAX)) begin
        stallCntR <= stallCntR + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stallCntR <= stallCntR;
      end
    end
  end

  assign bus.taken_cnt = takenCntR;
  assign bus.stall_cnt = stallCntR;

endmodule

// File: tb/tb_id_branch_ctrl.sv
// Directed bench for id_branch_ctrl with a cycle-level reference model and
// hand-computed spot checks.
module tb_id_branch_ctrl;
  localparam int LS   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  id_branch_ctrl_if #(.CNT_W(CW)) bus ();
  id_branch_ctrl #(.LOAD_STALL(LS), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model: stall budget per branch, table-driven conditions ----
  function automatic int needOf(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (bus.ex_we && bus.ex_rd == r) return bus.ex_is_load ? LS : 1;
    if (bus.mem_we && bus.mem_is_load && bus.mem_rd == r) return LS - 1;
    return 0;
  endfunction

  function automatic int fwdOf(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (bus.mem_we && !bus.mem_is_load && bus.mem_rd == r) return 1;
    if (bus.wb_we && bus.wb_rd == r) return 2;
    return 0;
  endfunction

  // Row per opcode, bit c set when comparator code c means taken.
  function automatic bit takenOf(input int op, input int c);
    bit [3:0] row;
    case (op)
      0:       row = 4'b0001;
      1:       row = 4'b0110;
      2:       row = 4'b0010;
      default: row = 4'b0101;
    endcase
    return row[c];
  endfunction

  bit mActive = 1'b0;
  int mLeft   = 0;
  int mTaken  = 0;
  int mStall  = 0;

  always @(negedge clk) begin : cmpProc
    int eStall, ePc, eFa, eFb, na, nb;
    bit res;
    eStall = 0; ePc = 0; eFa = 0; eFb = 0; res = 1'b0;
    if (!rst_n) begin
      mActive = 1'b0; mLeft = 0; mTaken = 0; mStall = 0;
    end else begin
      eFa = fwdOf(bus.rs1);
      eFb = fwdOf(bus.rs2);
      if (bus.ex_redirect) begin
        mActive = 1'b0;
      end else if (mActive) begin
        if (mLeft > 0) begin eStall = 1; mLeft--; end
        else begin res = 1'b1; mActive = 1'b0; end
      end else if (bus.br_valid) begin
        na = needOf(bus.rs1);
        nb = needOf(bus.rs2);
        if (nb > na) na = nb;
        if (na == 0) res = 1'b1;
        else begin eStall = 1; mActive = 1'b1; mLeft = na - 1; end
      end
      if (res && takenOf(int'(bus.br_op), int'(bus.cmp))) ePc = 1;
    end
    chk("m_stall",     int'(bus.stall),     eStall);
    chk("m_bubble_ex", int'(bus.bubble_ex), eStall);
    chk("m_pc_sel",    int'(bus.pc_sel),    ePc);
    chk("m_flush_if",  int'(bus.flush_if),  ePc);
    chk("m_fwd_a",     int'(bus.fwd_a),     eFa);
    chk("m_fwd_b",     int'(bus.fwd_b),     eFb);
    chk("m_taken_cnt", int'(bus.taken_cnt), mTaken);
    chk("m_stall_cnt", int'(bus.stall_cnt), mStall);
    if (rst_n) begin
      if (ePc == 1 && mTaken < CMAX) mTaken++;
      if (eStall == 1 && mStall < CMAX) mStall++;
    end
  end

  // ---- stimulus ----
  task automatic clearIn();
    bus.br_valid = 1'b0; bus.br_op = 2'b00; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
    bus.mem_we = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd = 5'd0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.cmp = 2'b00; bus.ex_redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearIn();
    // Reset: outputs forced low even with a WB match present.
    bus.br_valid = 1'b1; bus.rs1 = 5'd3; bus.wb_we = 1'b1; bus.wb_rd = 5'd3;
    #3;
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_pc_sel", int'(bus.pc_sel), 0);
    chk("rst_fwd_a", int'(bus.fwd_a), 0);
    chk("rst_taken_cnt", int'(bus.taken_cnt), 0);
    tick(); tick();
    clearIn();
    rst_n = 1'b1;
    tick();

    // 1: no hazard, BEQ taken in the same cycle.
    bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.rs1 = 5'd3; bus.rs2 = 5'd4; bus.cmp = 2'b00;
    #2;
    chk("t1_pc_sel", int'(bus.pc_sel), 1);
    chk("t1_flush_if", int'(bus.flush_if), 1);
    chk("t1_stall", int'(bus.stall), 0);
    chk("t1_fwd_a", int'(bus.fwd_a), 0);
    tick(); clearIn(); #2;
    chk("t1_taken_cnt", int'(bus.taken_cnt), 1);
    tick();

    // 2: EX load hazard, two stall cycles then BLT taken.
    bus.br_valid = 1'b1; bus.br_op = 2'b10; bus.rs1 = 5'd5; bus.cmp = 2'b01;
    bus.ex_we = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    #2; chk("t2_stall_c1", int'(bus.stall), 1);
    tick();
    bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
    bus.mem_we = 1'b1; bus.mem_is_load = 1'b1; bus.mem_rd = 5'd5;
    #2; chk("t2_stall_c2", int'(bus.stall), 1);
    tick();
    bus.mem_we = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd = 5'd0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd5;
    #2;
    chk("t2_stall_c3", int'(bus.stall), 0);
    chk("t2_pc_sel", int'(bus.pc_sel), 1);
    chk("t2_fwd_a", int'(bus.fwd_a), 2);
    chk("t2_stall_cnt", int'(bus.stall_cnt), 2);
    tick(); clearIn(); #2;
    chk("t2_taken_cnt", int'(bus.taken_cnt), 2);
    tick();

    // 3: forwarding from MEM (rs2) and WB (rs1), BNE not taken.
    bus.br_valid = 1'b1; bus.br_op = 2'b01; bus.rs1 = 5'd9; bus.rs2 = 5'd7; bus.cmp = 2'b00;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd7; bus.wb_we = 1'b1; bus.wb_rd = 5'd9;
    #2;
    chk("t3_fwd_b", int'(bus.fwd_b), 1);
    chk("t3_fwd_a", int'(bus.fwd_a), 2);
    chk("t3_stall", int'(bus.stall), 0);
    chk("t3_pc_sel", int'(bus.pc_sel), 0);
    chk("t3_flush_if", int'(bus.flush_if), 0);
    tick(); clearIn();

    // 4a: x0 never matches.
    bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.cmp = 2'b01;
    bus.ex_we = 1'b1; bus.ex_rd = 5'd0;
    #2; chk("t4_x0_stall", int'(bus.stall), 0);
    tick(); clearIn();

    // 4b: MEM non-load beats WB.
    bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.rs1 = 5'd6; bus.cmp = 2'b01;
    bus.mem_we = 1'b1; bus.mem_rd = 5'd6; bus.wb_we = 1'b1; bus.wb_rd = 5'd6;
    #2;
    chk("t4_fwd_a", int'(bus.fwd_a), 1);
    chk("t4_stall", int'(bus.stall), 0);
    tick(); clearIn();

    // 7: MEM load costs LOAD_STALL-1 = 1 cycle, BGE on GT taken.
    bus.br_valid = 1'b1; bus.br_op = 2'b11; bus.rs2 = 5'd10; bus.cmp = 2'b10;
    bus.mem_we = 1'b1; bus.mem_is_load = 1'b1; bus.mem_rd = 5'd10;
    #2; chk("t7_stall", int'(bus.stall), 1);
    tick();
    bus.mem_we = 1'b0; bus.mem_is_load = 1'b0; bus.mem_rd = 5'd0;
    bus.wb_we = 1'b1; bus.wb_rd = 5'd10;
    #2;
    chk("t7_stall_res", int'(bus.stall), 0);
    chk("t7_pc_sel", int'(bus.pc_sel), 1);
    chk("t7_fwd_b", int'(bus.fwd_b), 2);
    tick(); clearIn();

    // 8: illegal comparator code is not taken, even for BNE.
    bus.br_valid = 1'b1; bus.br_op = 2'b01; bus.cmp = 2'b11;
    #2; chk("t8_pc_sel", int'(bus.pc_sel), 0);
    tick(); clearIn();

    // 5a: EX ALU hazard killed by an older redirect.
    bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.rs2 = 5'd8; bus.cmp = 2'b00;
    bus.ex_we = 1'b1; bus.ex_rd = 5'd8;
    #2; chk("t5_stall_c1", int'(bus.stall), 1);
    tick();
    bus.ex_we = 1'b0; bus.ex_rd = 5'd0; bus.ex_redirect = 1'b1;
    #2;
    chk("t5_kill_stall", int'(bus.stall), 0);
    chk("t5_kill_pc_sel", int'(bus.pc_sel), 0);
    chk("t5_kill_flush", int'(bus.flush_if), 0);
    tick();
    bus.ex_redirect = 1'b0; bus.br_valid = 1'b0;
    #2;
    chk("t5_idle_pc_sel", int'(bus.pc_sel), 0);
    chk("t5_taken_cnt", int'(bus.taken_cnt), 3);
    chk("t5_stall_cnt", int'(bus.stall_cnt), 4);
    tick(); clearIn();

    // 5b: async reset in the middle of WAIT.
    bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.rs1 = 5'd11; bus.cmp = 2'b00;
    bus.ex_we = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd11;
    #2; chk("t5b_stall_c1", int'(bus.stall), 1);
    tick();
    bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
    #1; chk("t5b_stall_wait", int'(bus.stall), 1);
    #1; rst_n = 1'b0;
    #1;
    chk("t5b_rst_stall", int'(bus.stall), 0);
    chk("t5b_rst_taken_cnt", int'(bus.taken_cnt), 0);
    chk("t5b_rst_stall_cnt", int'(bus.stall_cnt), 0);
    clearIn();
    tick();
    rst_n = 1'b1;
    tick();

    // 6: 2^CNT_W+3 taken BGE branches saturate taken_cnt.
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      bus.br_valid = 1'b1; bus.br_op = 2'b11; bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.cmp = 2'b10;
      tick();
    end
    clearIn(); #2;
    chk("t6_taken_sat", int'(bus.taken_cnt), 15);
    tick();

    // Stall counter saturation: 8 load-hazard branches = 16 stall cycles.
    for (int i = 0; i < 8; i++) begin
      bus.br_valid = 1'b1; bus.br_op = 2'b00; bus.rs1 = 5'd12; bus.cmp = 2'b01;
      bus.ex_we = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd12;
      tick();
      bus.ex_we = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
      tick();
      tick();
    end
    clearIn(); #2;
    chk("t6_stall_sat", int'(bus.stall_cnt), 15);
    chk("t6_taken_hold", int'(bus.taken_cnt), 15);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_branch_ctrl.md
Name: id_branch_ctrl

Overview:
- ID-stage branch resolution controller for the pipelined CPU.
- Detects data hazards on the branch operands and stalls the front end for the required cycles.
- Drives the ID-stage forwarding selects for the comparator operands and interprets the comparator's 2-bit result (EQ/LT/GT) per branch opcode.
- Issues the PC redirect plus IF/ID flush on a taken branch, and keeps saturating performance counters.

Parameters:
- LOAD_STALL, 2, stall cycles when a load producing a branch operand is in EX (legal 2..3). A MEM-stage load producer costs LOAD_STALL-1.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  branch instruction present in ID.
- br_op  in  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE (signed).
- rs1, rs2  in  5 each  branch source registers.
- ex_we, ex_is_load  in  1 each  EX-stage instruction writes a register / is a load.
- ex_rd  in  5  EX destination.
- mem_we, mem_is_load  in  1 each  MEM-stage equivalents.
- mem_rd  in  5  MEM destination.
- wb_we  in  1  WB-stage register write.
- wb_rd  in  5  WB destination.
- cmp  in  2  comparator result: 00 EQ, 01 LT, 10 GT.
- ex_redirect  in  1  older instruction in EX redirects the PC; kills the ID branch.
- stall  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX; equals stall.
- pc_sel  out  1  select branch target as next PC.
- flush_if  out  1  squash the IF/ID register.
- fwd_a, fwd_b  out  2 each  operand source: 00 regfile, 01 MEM-stage ALU result, 10 WB data.
- taken_cnt  out  CNT_W  taken branches, saturating.
- stall_cnt  out  CNT_W  branch-induced stall cycles, saturating.

Behaviour:
- Reset (rst_n low, async): state IDLE, cnt 0, taken_cnt 0, stall_cnt 0. All combinational outputs are forced 0 while rst_n is low.
- Operand match: rsX != 0 and equals a stage's rd with that stage's we=1. x0 never matches.
- Stall requirement n is the maximum over both operands:
  - EX load match: n = LOAD_STALL.
  - EX non-load match: n = 1.
  - MEM load match: n = LOAD_STALL-1.
  - Otherwise n = 0.
- Forwarding selects, per operand, combinational in every state:
  - MEM non-load match gives 01.
  - Else WB match gives 10.
  - Else 00.
  - MEM has priority over WB.
- FSM state IDLE:
  - br_valid=0: all outputs 0.
  - br_valid=1 and n=0: resolve this cycle (see RESOLVE action), stay IDLE.
  - br_valid=1 and n>0: stall=1. Then n=1 goes to RESOLVE; n>1 goes to WAIT with cnt=n-1.
- FSM state WAIT: stall=1, cnt decrements. At cnt==1 go to RESOLVE. Hazards are not re-evaluated.
- FSM state RESOLVE: stall=0, resolve action, then go to IDLE. Hazards are not re-evaluated.
- Resolve action: taken is computed as
  - BEQ: cmp==EQ.
  - BNE: cmp!=EQ.
  - BLT: cmp==LT.
  - BGE: cmp==EQ or cmp==GT.
  - cmp=11 (illegal) is treated as not-taken.
  - taken=1 asserts pc_sel=1 and flush_if=1 for exactly that cycle.
- Branch latency: 0 stall cycles with no hazard, n cycles otherwise. The redirect is always in the resolve cycle.
- ex_redirect=1 has top priority in any state:
  - Outputs stall, pc_sel, flush_if = 0.
  - Next state IDLE, cnt 0.
  - No counter increment.
- Counters:
  - taken_cnt += 1 on each resolve with taken=1.
  - stall_cnt += 1 each cycle stall=1.
  - Both saturate at all-ones with no wrap.
- br_valid dropping in WAIT is ignored; stall holds the instruction, so this cannot occur legally.
- Async reset asserted mid-WAIT returns to IDLE immediately, with the counters cleared.

Test Plan:
1. No hazard: br_valid=1, BEQ, rs1=3, rs2=4, no matches, cmp=00 -> same cycle pc_sel=1, flush_if=1, stall=0, fwd_a=fwd_b=00, taken_cnt=1.
2. EX load hazard: rs1=5, ex_rd=5, ex_we=1, ex_is_load=1, LOAD_STALL=2 -> stall=1 for 2 cycles (IDLE, WAIT), RESOLVE on cycle 3. Then BLT with cmp=01 gives pc_sel=1, and stall_cnt=2.
3. Forwarding: BNE, rs2=7 with mem_rd=7 non-load, and rs1=9 with wb_rd=9 -> fwd_b=01, fwd_a=10, stall=0. cmp=00 gives not-taken: pc_sel=0, flush_if=0.
4. x0 and priority: rs1=0 with ex_rd=0, ex_we=1 -> no stall. rs1=6 matching both mem_rd and wb_rd (MEM non-load) -> fwd_a=01.
5. Kill: EX ALU hazard, stall=1 in IDLE; next cycle ex_redirect=1 -> stall=0, pc_sel=0, state IDLE, taken_cnt unchanged. Async rst_n pulse mid-WAIT -> outputs 0 immediately, counters 0.
6. Saturation: preload-free run of 2^CNT_W+3 taken BGE (cmp=10) with CNT_W=4 -> taken_cnt holds 4'hF.
